// File: rtl/sd_timer_bank.sv
// sd_timer_bank: bank of independent down-counting timers for the SD host.
// Each channel loads a runtime value on start, counts qualified ticks down
// to zero, and pulses expire on the terminal-count tick. In periodic mode the
// channel reloads and keeps running. Each channel also has a sticky flag that
// is cleared by software.
//
// Per-channel FSM:
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | counter parked at 0, waiting for start (stop ignored)
//   RUN   | counting qualified ticks; stop > start > terminal count > dec
module sd_timer_bank #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick_en,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       periodic,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    input  logic [CHANNELS-1:0]       clear_flag,
    output logic [CHANNELS-1:0]       expire,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       flag,
    output logic [CHANNELS*WIDTH-1:0] count_q
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch

        state_t           state_q, state_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] ld;
        logic             mode_q, mode_d;
        logic             exp_q, exp_d;
        logic             flag_q, flag_d;
        logic             at_zero;
        logic             busy_c;

        assign ld      = load_value[ch*WIDTH +: WIDTH];
        assign at_zero = (cnt_q == '0);

        // State register: FSM state, counter, latched mode, expire pulse, flag.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                mode_q  <= 1'b0;
                exp_q   <= 1'b0;
                flag_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                mode_q  <= mode_d;
                exp_q   <= exp_d;
                flag_q  <= flag_d;
            end
        end

        // Next-state: prioritised RUN decisions; the start cycle never counts.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            mode_d  = mode_q;
            exp_d   = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start[ch]) begin
                        state_d = ST_RUN;
                        cnt_d   = ld;
                        mode_d  = periodic[ch];
                    end
                end
                ST_RUN: begin
                    if (stop[ch]) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (start[ch]) begin
                        cnt_d  = ld;
                        mode_d = periodic[ch];
                    end else if (tick_en) begin
                        if (at_zero) begin
                            exp_d = 1'b1;
                            if (mode_q) begin
                                cnt_d = ld;
                            end else begin
                                state_d = ST_IDLE;
                                cnt_d   = '0;
                            end
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
            // A new expire beats a simultaneous clear.
            flag_d = exp_d | (flag_q & ~clear_flag[ch]);
        end

        // Outputs: everything comes straight from registers.
        always_comb begin
            busy_c = (state_q == ST_RUN);
        end

        assign busy[ch]                     = busy_c;
        assign expire[ch]                   = exp_q;
        assign flag[ch]                     = flag_q;
        assign count_q[ch*WIDTH +: WIDTH]   = cnt_q;
    end

endmodule

// File: tb/tb_sd_timer_bank.sv
// Directed self-checking bench for sd_timer_bank (WIDTH=16, CHANNELS=4).
module tb_sd_timer_bank;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           tick_en;
    logic [N-1:0]   start, stop, periodic, clear_flag;
    logic [N*W-1:0] load_value;
    logic [N-1:0]   expire, busy, flag;
    logic [N*W-1:0] count_q;

    int compared   = 0;
    int mismatched = 0;

    sd_timer_bank #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_en    (tick_en),
        .start      (start),
        .stop       (stop),
        .periodic   (periodic),
        .load_value (load_value),
        .clear_flag (clear_flag),
        .expire     (expire),
        .busy       (busy),
        .flag       (flag),
        .count_q    (count_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input int ch, input logic [W-1:0] v);
        load_value[ch*W +: W] = v;
    endtask

    function automatic logic [W-1:0] cnt(input int ch);
        return count_q[ch*W +: W];
    endfunction

    initial begin
        logic [N-1:0] exp_v;

        reset      = 1'b1;
        tick_en    = 1'b0;
        start      = '0;
        stop       = '0;
        periodic   = '0;
        clear_flag = '0;
        load_value = '0;

        // ---- reset state
        #23;
        chk("rst_busy",   busy,    0);
        chk("rst_expire", expire,  0);
        chk("rst_flag",   flag,    0);
        chk("rst_count",  count_q, 0);
        reset = 1'b0;
        cyc();

        // ---- one-shot ch0, load 3
        set_load(0, 16'd3);
        tick_en  = 1'b1;
        start[0] = 1'b1;
        cyc();
        start[0] = 1'b0;
        chk("os_busy0", busy[0], 1);
        for (int k = 3; k >= 0; k--) begin
            chk("os_count", cnt(0), k);
            chk("os_noexp", expire[0], 0);
            if (k > 0) cyc();
        end
        cyc();
        chk("os_expire", expire[0], 1);
        chk("os_busy",   busy[0],   0);
        chk("os_flag",   flag[0],   1);
        chk("os_cnt0",   cnt(0),    0);
        cyc();
        chk("os_pulse1", expire[0], 0);
        chk("os_sticky", flag[0],   1);
        clear_flag[0] = 1'b1;
        cyc();
        clear_flag[0] = 1'b0;
        chk("os_clr", flag[0], 0);

        // ---- periodic ch1, load 2, tick every other cycle
        set_load(1, 16'd2);
        periodic[1] = 1'b1;
        tick_en     = 1'b0;
        start[1]    = 1'b1;
        cyc();
        start[1] = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            tick_en = i[0];
            cyc();
            chk("per_expire", expire[1], (i >= 5 && ((i - 5) % 6) == 0) ? 1 : 0);
            chk("per_busy",   busy[1],   1);
        end
        stop[1] = 1'b1;
        cyc();
        stop[1] = 1'b0;
        chk("per_stop_busy", busy[1],   0);
        chk("per_stop_exp",  expire[1], 0);
        chk("per_stop_cnt",  cnt(1),    0);

        // ---- ch2 load 0 periodic: expire on every qualified tick
        set_load(2, 16'd0);
        periodic[2] = 1'b1;
        tick_en     = 1'b1;
        start[2]    = 1'b1;
        cyc();
        start[2] = 1'b0;
        chk("z_first_noexp", expire[2], 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("z_expire", expire[2], 1);
            chk("z_cnt",    cnt(2),    0);
        end
        tick_en = 1'b0;
        cyc();
        chk("z_gap", expire[2], 0);
        tick_en = 1'b1;
        cyc();
        chk("z_resume", expire[2], 1);
        stop[2] = 1'b1;
        cyc();
        stop[2] = 1'b0;
        chk("z_stop", busy[2], 0);

        // ---- ch2 max load one-shot: 65536 ticks, no wrap
        set_load(2, 16'hFFFF);
        periodic[2] = 1'b0;
        start[2]    = 1'b1;
        cyc();
        start[2] = 1'b0;
        chk("max_load", cnt(2), 16'hFFFF);
        repeat (65535) cyc();
        chk("max_zero",   cnt(2),    0);
        chk("max_noexp",  expire[2], 0);
        chk("max_busy",   busy[2],   1);
        cyc();
        chk("max_expire", expire[2], 1);
        chk("max_idle",   busy[2],   0);
        chk("max_nowrap", cnt(2),    0);

        // ---- priority: start+stop together in RUN
        set_load(0, 16'd5);
        periodic[0] = 1'b0;
        start[0]    = 1'b1;
        cyc();
        stop[0] = 1'b1;
        cyc();
        start[0] = 1'b0;
        stop[0]  = 1'b0;
        chk("ss_busy",   busy[0],   0);
        chk("ss_noexp",  expire[0], 0);
        chk("ss_cnt",    cnt(0),    0);
        cyc();
        chk("ss_noexp2", expire[0], 0);

        // ---- priority: start on terminal-count cycle reloads, no expire
        set_load(0, 16'd1);
        start[0] = 1'b1;
        cyc();
        start[0] = 1'b0;
        cyc();
        chk("tc_at0", cnt(0), 0);
        set_load(0, 16'd3);
        start[0] = 1'b1;
        cyc();
        start[0] = 1'b0;
        chk("tc_noexp",  expire[0], 0);
        chk("tc_reload", cnt(0),    3);
        chk("tc_busy",   busy[0],   1);
        stop[0] = 1'b1;
        cyc();
        stop[0] = 1'b0;

        // ---- flag set and clear in the same cycle: set wins
        set_load(0, 16'd0);
        start[0] = 1'b1;
        cyc();
        start[0]      = 1'b0;
        clear_flag[0] = 1'b1;
        cyc();
        clear_flag[0] = 1'b0;
        chk("fc_expire", expire[0], 1);
        chk("fc_flag",   flag[0],   1);
        cyc();
        chk("fc_hold", flag[0], 1);

        // ---- reset mid-operation on ch3
        set_load(3, 16'd0);
        start[3] = 1'b1;
        cyc();
        start[3] = 1'b0;
        cyc();
        chk("r3_flag", flag[3], 1);
        set_load(3, 16'd8);
        start[3] = 1'b1;
        cyc();
        start[3] = 1'b0;
        repeat (3) cyc();
        chk("r3_cnt5", cnt(3), 5);
        #3;
        reset = 1'b1;
        #1;
        chk("ra_busy",   busy,    0);
        chk("ra_expire", expire,  0);
        chk("ra_flag",   flag,    0);
        chk("ra_count",  count_q, 0);
        #2;
        reset = 1'b0;
        repeat (3) cyc();
        chk("ra_stay_idle", busy[3], 0);
        chk("ra_stay_cnt",  cnt(3),  0);
        chk("ra_no_exp",    expire,  0);

        // ---- independence: loads 1..4, all started together
        for (int c = 0; c < N; c++) set_load(c, 16'(c + 1));
        periodic = '0;
        start    = '1;
        cyc();
        start = '0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            for (int c = 0; c < N; c++) exp_v[c] = (i == c + 2);
            chk("ind_expire", expire, exp_v);
        end
        chk("ind_done", busy, 0);

        // ---- independence with ch1 stopped before its expire
        start = '1;
        cyc();
        start = '0;
        cyc();
        stop[1] = 1'b1;
        cyc();
        stop[1] = 1'b0;
        chk("st_expire2", expire, 4'b0001);
        chk("st_busy2",   busy,   4'b1100);
        cyc();
        chk("st_expire3", expire, 4'b0000);
        cyc();
        chk("st_expire4", expire, 4'b0100);
        cyc();
        chk("st_expire5", expire, 4'b1000);
        chk("st_busy5",   busy,   4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sd_timer_bank.md
Name: sd_timer_bank

Overview:
- Multi-channel programmable down-counting timer bank for the SD host controller.
- Serves command-response timeout, data-read timeout, busy-wait and the 74-clock init delay.
- Generalises the single fixed-compare pulse counter:
  - parametrised width and channel count
  - runtime load value per channel
  - one-shot or periodic mode
  - external tick qualifier, so channels can count SD-clock edges instead of system clocks
  - stop/abort
  - sticky per-channel timeout flags

Parameters:
- WIDTH, 16, bit width of each channel counter and load value.
- CHANNELS, 4, number of independent timer channels (1..16).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- tick_en  input  1  global count qualifier; counters advance only in cycles where it is high.
- start  input  CHANNELS  per-channel start/restart strobe.
- stop  input  CHANNELS  per-channel abort strobe.
- periodic  input  CHANNELS  per-channel mode, sampled at start: 1 = periodic, 0 = one-shot.
- load_value  input  CHANNELS*WIDTH  per-channel reload value; channel n occupies bits [n*WIDTH +: WIDTH].
- clear_flag  input  CHANNELS  per-channel sticky-flag clear strobe.
- expire  output  CHANNELS  one-cycle pulse on terminal count.
- busy  output  CHANNELS  high while the channel is in RUN.
- flag  output  CHANNELS  sticky expire indicator.
- count_q  output  CHANNELS*WIDTH  current counter value per channel, same packing as load_value.

Behaviour:
- Reset (asynchronous): all outputs are 0, every channel is in IDLE, all counters are 0 and all latched modes are 0.
- Channels are fully independent. The description below is per channel n.
- States: IDLE and RUN. busy = (state == RUN), registered.
- IDLE:
  - start=1 → load counter with load_value[n], latch periodic[n] into mode_q, go to RUN next cycle.
  - Otherwise hold.
- RUN, evaluated in priority order each cycle:
  1. stop=1 → go to IDLE, counter cleared to 0, no expire pulse.
  2. start=1 → reload counter with load_value, re-latch mode, stay in RUN, no expire pulse, even if the counter was 0 with tick_en high.
  3. tick_en=1 and counter==0 → expire=1 for exactly this cycle (registered, visible the following cycle edge).
     - If mode_q=1: reload load_value and stay in RUN.
     - Else: go to IDLE with counter 0.
  4. tick_en=1 and counter!=0 → counter decrements by 1.
  5. tick_en=0 → hold everything.
- Timing:
  - Period is load_value+1 qualified ticks.
  - load_value=0 gives expire on the first qualified tick after start.
  - In periodic mode, load_value=0 gives expire on every qualified tick.
  - Maximum load_value is 2^WIDTH-1. No wrap-around is possible because the counter never decrements below 0.
- The start cycle itself does not count, even if tick_en is high in that cycle.
- stop and start asserted together in RUN: stop wins. In IDLE, stop is ignored, so start wins.
- Flag:
  - Set in the cycle expire is asserted.
  - Cleared by clear_flag.
  - Set and clear in the same cycle: set wins.
  - Unaffected by start and stop.
- count_q reflects the registered counter value. In IDLE it is 0 after expire or stop, and retains 0 after reset.
- load_value and periodic are sampled only on start or periodic reload. Changing load_value while in RUN affects the next periodic reload only.
- Reset asserted mid-count returns the channel to the reset state immediately. After deassertion nothing restarts until a new start.

Test Plan:
- One-shot: ch0 load_value=3, periodic=0, tick_en=1 constant, start pulse at cycle 0.
  → count_q 3,2,1,0; expire high 4 cycles after start is registered; busy falls the same cycle; flag=1 and remains set.
- Periodic with qualifier: ch1 load_value=2, periodic=1, tick_en high every other cycle.
  → expire every 6 clk cycles; busy stays 1; three pulses observed in 18 cycles after the first.
- Boundary: ch2 load_value=0 periodic → expire on every cycle with tick_en=1. Separately, load_value=16'hFFFF one-shot → expire after exactly 65536 ticks, no wrap.
- Priority:
  - start and stop together in RUN → busy=0 next cycle, no expire.
  - start on the terminal-count cycle → no expire and count_q reloads.
  - flag set and clear_flag in the same cycle → flag stays 1.
- Reset mid-operation: ch3 running at count_q=5 and flag=1, assert reset asynchronously between clock edges.
  → all outputs 0 immediately. After release, the channel stays IDLE with tick_en=1 until start.
- Independence: start all 4 channels with load values 1,2,3,4.
  → expire pulses occur on consecutive cycles 2,3,4,5 after start; stopping ch1 does not disturb the others.
